// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: word field layout,
// opcodes that fetch cares about, and the sequencer state encoding.
package fetch_pkg;

    localparam int TYPE_MSB = 23;
    localparam int TYPE_LSB = 22;
    localparam int OPC_MSB  = 21;
    localparam int OPC_LSB  = 17;
    localparam int IMM_MSB  = 16;
    localparam int IMM_LSB  = 0;

    localparam logic [1:0] TYPE_JUMP = 2'b00;

    localparam logic [4:0] OPC_J   = 5'b01100;
    localparam logic [4:0] OPC_JAL = 5'b01101;
    localparam logic [4:0] OPC_JR  = 5'b00110;

    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational J/JAL recognition and jump-target extraction for a fetched word.
module fetch_predecode
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int INSTR_W = 24
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic               is_j_o,
    output logic               is_jal_o,
    output logic [ADDR_W-1:0]  target_o
);

    logic [1:0]  word_type;
    logic [4:0]  word_opc;
    logic [16:0] word_imm;

    always_comb begin
        word_type = instr_i[TYPE_MSB:TYPE_LSB];
        word_opc  = instr_i[OPC_MSB:OPC_LSB];
        word_imm  = instr_i[IMM_MSB:IMM_LSB];
        is_j_o    = (word_type == TYPE_JUMP) && (word_opc == OPC_J);
        is_jal_o  = (word_type == TYPE_JUMP) && (word_opc == OPC_JAL);
        target_o  = ADDR_W'(word_imm);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, resolves J/JAL in fetch, feeds decode
// through a one-entry valid/ready stage and parks on the self-jump idiom.
//   state   | meaning
//   ST_RUN  | fetching, capturing into the output stage
//   ST_HALT | PC frozen after "J self"; only a redirect or reset leaves
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int INSTR_W  = 24,
    parameter int PC_STEP  = 3,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  ReadAddress,
    input  logic [INSTR_W-1:0] Instruction,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               RedirectValid,
    input  logic [ADDR_W-1:0]  RedirectTarget,
    output logic               LinkWe,
    output logic [ADDR_W-1:0]  LinkData,
    output logic               Halted,
    output logic [CNT_W-1:0]   FetchCount
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_j;
    logic               is_jal;
    logic [ADDR_W-1:0]  jump_target;
    logic               stall;
    logic               handshake;
    logic               capture;
    logic [ADDR_W-1:0]  pc_inc;

    fetch_predecode #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_predecode (
        .instr_i  (Instruction),
        .is_j_o   (is_j),
        .is_jal_o (is_jal),
        .target_o (jump_target)
    );

    assign stall     = valid_q && !InstrReady;
    assign handshake = valid_q && InstrReady;
    assign capture   = (state_q == ST_RUN) && !RedirectValid && !stall;
    assign pc_inc    = pc_q + ADDR_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (capture && is_j && (jump_target == pc_q)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (RedirectValid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // LinkWe is combinational so the R7 write lands in the same cycle the JAL is consumed.
    always_comb begin
        ReadAddress = pc_q;
        Halted      = (state_q == ST_HALT);
        LinkWe      = !reset && capture && is_jal;
        LinkData    = LinkWe ? pc_inc : '0;
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q && !handshake;
        cnt_d   = cnt_q;

        if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (RedirectValid) begin
            pc_d    = RedirectTarget;
            valid_d = 1'b0;
        end else if (capture) begin
            if (is_j || is_jal) begin
                pc_d    = jump_target;
                valid_d = 1'b0;
            end else begin
                instr_d = Instruction;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= ADDR_W'(RESET_PC);
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrOut   = instr_q;
    assign InstrPC    = ipc_q;
    assign InstrValid = valid_q;
    assign FetchCount = cnt_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 24-bit MIPS-style core. Owns the PC, drives the combinational instruction ROM address, and registers each fetched word into a one-entry output stage with a valid/ready handshake to decode.
- Resolves J/JAL in fetch and emits the JAL link write for R7.
- Accepts redirects (JR, taken BEQ) from the execute stage.
- Detects the self-jump "J end" idiom and parks in a HALT state.

Parameters:
- ADDR_W, 24, PC and ROM address width
- INSTR_W, 24, instruction width
- PC_STEP, 3, PC increment per instruction (byte address, 3-byte words)
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of the delivered-instruction counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high reset
- ReadAddress  out  ADDR_W  ROM address; always equals PC (combinational from the PC register)
- Instruction  in  INSTR_W  ROM data, valid in the same cycle as ReadAddress
- InstrOut  out  INSTR_W  registered instruction to decode
- InstrPC  out  ADDR_W  address of InstrOut
- InstrValid  out  1  InstrOut holds a live instruction
- InstrReady  in  1  decode accepts InstrOut this cycle
- RedirectValid  in  1  execute requests a PC change (JR or taken BEQ)
- RedirectTarget  in  ADDR_W  new PC
- LinkWe  out  1  one-cycle pulse: write LinkData to R7
- LinkData  out  ADDR_W  JAL return address (PC+PC_STEP)
- Halted  out  1  sequencer is parked in HALT
- FetchCount  out  CNT_W  number of handshakes accepted by decode (saturating)

Behaviour:
- Reset (sync, active-high, highest priority; also mid-operation): PC=RESET_PC, state=RUN, InstrValid=0, InstrOut=0, InstrPC=0, LinkWe=0, LinkData=0, Halted=0, FetchCount=0.
- Word fields: type=[23:22], opcode=[21:17], J-immediate=[16:0]. J = type 00 with opcode 01100; JAL = type 00 with opcode 01101. Jump target = zero-extended imm17.
- "Stall" = InstrValid && !InstrReady. "Capture" = state RUN, no redirect, not stall.
- States:
  - RUN: normal fetch.
  - HALT: PC frozen, no captures, Halted=1.
- Per-cycle priority in RUN:
  1. RedirectValid: PC<=RedirectTarget; InstrValid<=0 (flush, even if stalled); no capture; no LinkWe.
  2. Stall: PC, InstrOut, InstrPC and InstrValid hold.
  3. Capture with J/JAL fetched: the word is consumed in fetch and not forwarded; InstrValid<=0 unless a handshake also completes this cycle (then InstrValid<=0 anyway).
     - PC<=target.
     - JAL additionally: LinkWe=1 for exactly this cycle, LinkData=PC+PC_STEP.
     - J whose target == PC: go to HALT, PC holds, Halted<=1.
  4. Capture otherwise: InstrOut<=Instruction, InstrPC<=PC, InstrValid<=1, PC<=PC+PC_STEP.
- Handshake: InstrValid && InstrReady completes a transfer and increments FetchCount, saturating at all-ones. InstrValid then drops unless a new capture loads the stage in the same cycle. Back-to-back single-cycle throughput with InstrReady=1.
- HALT:
  - A pending InstrValid may still drain; its handshake counts.
  - RedirectValid: PC<=RedirectTarget, state<=RUN, Halted<=0, InstrValid<=0.
  - Leaving HALT otherwise requires reset.
- Arithmetic: PC+PC_STEP wraps modulo 2^ADDR_W. No alignment check on redirect targets.
- ROM default word 0 (NOOP) is forwarded like any other instruction.
- Latency: ROM word at PC appears on InstrOut one cycle after PC is presented.

Decomposition:
- Shared package fetch_pkg holds:
  - field positions TYPE_MSB/LSB and OPC_MSB/LSB
  - opcode constants OPC_J=5'b01100, OPC_JAL=5'b01101, OPC_JR=5'b00110
  - LINK_REG=3'd7
  - state encoding ST_RUN, ST_HALT
- Optional sub-module fetch_predecode: combinational is_j, is_jal, target from the instruction word.

Test Plan:
- Test program 1, InstrReady=1: reset, release. Expected:
  - cycle 0: ReadAddress=0, LinkWe=1, LinkData=3, then PC=6.
  - Forwarded InstrPC sequence: 6, 9, 12, 15.
  - FetchCount=4 after the JR at 15 handshakes.
- JR redirect: when InstrPC=15 is valid, drive RedirectValid=1, RedirectTarget=3. Expected: J at 3 targets 3, so Halted=1 next cycle, ReadAddress stays 3, no further InstrValid.
- Stall: hold InstrReady=0 after the word at 6 is captured. Expected: InstrOut and InstrPC=6 held, PC=9 frozen. Release: handshake, then InstrPC=9 next cycle.
- Redirect during stall: InstrValid=1, InstrReady=0, RedirectValid=1, target 12. Expected next cycle: InstrValid=0, PC=12, FetchCount unchanged.
- Reset mid-run at PC=12 with InstrValid=1. Expected next cycle: PC=0, InstrValid=0, FetchCount=0, Halted=0.
- Counter saturation with CNT_W=2: deliver 5 instructions. Expected: FetchCount sticks at 3.
